i8254_counter_channel: RTL
==========================

Name: i8254_counter_channel

Overview:
Parametrised 8254-style counter channel. It supersedes the fixed 16-bit, write-only counter and adds:
- a generic count width;
- all six counting modes;
- a counter-latch/read-back path;
- an explicit count-tick strobe.

It sits behind the chip's bus/control decoder, one instance per channel. A single system clock drives everything, and counting advances only on `cnt_tick`.

Parameters:
- WIDTH, 16: counter width in bits; multiple of 8, range 8..32.
- BYTES, WIDTH/8: derived; bytes per full count transfer.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- cnt_tick  in  1  one-cycle count strobe (the 8254 CLK pin equivalent).
- gate  in  1  gate input; synchronous to clk.
- ctrl_we  in  1  control-word write strobe.
- ctrl_word  in  6  {RW[1:0], M[2:0], BCD}.
- data_we  in  1  data-byte write strobe (the DE equivalent).
- data_in  in  8  count byte.
- data_re  in  1  data-byte read strobe.
- data_out  out  8  read byte; registered.
- out  out  1  counter output.
- count_value  out  WIDTH  live count element (debug/observation).
- null_count  out  1  high from count write until the count is loaded into the counting element.

Behaviour:
- Reset:
  - mode=0, RW=11, BCD=0.
  - count, count register and output latch = 0.
  - out=0, null_count=1, data_out=0.
  - byte pointers at LSB; state IDLE.
- Control-word write, RW≠00:
  - Stores mode, RW and BCD; resets byte pointers; null_count=1; state IDLE.
  - out: low in mode 0, high in all other modes.
  - M=110/111 alias modes 2/3.
- Control-word write, RW=00 (latch command):
  - Snapshots count_value into the output latch.
  - Further latch commands are ignored until the latch has been fully read.
- Data writes:
  - RW=01: LSB only; upper bytes zero.
  - RW=10: MSB only; lower bytes zero.
  - RW=11: BYTES writes, LSB first.
  - The count register updates after the final byte; any new data_we after that starts a new sequence.
- Reads:
  - Same byte order as writes, taken from the latch if one is held, else from the live count.
  - data_out is valid the cycle after data_re.
  - A read and a write in the same cycle keep independent pointers.
- Count value 0 means 2^WIDTH (binary) or 10^(2·BYTES) (BCD).
- State machine:
  - IDLE: no count yet. Leaves on count-register completion, to LOAD_PEND in modes 0/2/3/4. Modes 1/5 go to ARMED.
  - ARMED (modes 1/5): waits for a gate rising edge (gate & ~gate_q), then LOAD_PEND.
  - LOAD_PEND: on the next cnt_tick, copy the count register to the count, clear null_count, go to COUNTING.
  - COUNTING: decrement on cnt_tick, with gate qualification per mode.
- Mode 0:
  - out low from the count write; high at count 0 and stays high.
  - Gate low pauses counting.
  - A new count write restarts the count (out low).
- Mode 1: out low at load; high at count 0. A gate rising edge retriggers (reload on the next tick).
- Mode 2:
  - out high; low for exactly one tick when count=1, then reload.
  - Gate low forces out high and stops counting; a gate rising edge reloads.
- Mode 3:
  - Decrement by 2; out toggles and reloads at terminal count.
  - Even N: N/2 ticks high, N/2 ticks low.
  - Odd N: (N+1)/2 ticks high, (N-1)/2 ticks low.
  - Gate behaves as in mode 2.
- Mode 4: out high; low for one tick when count reaches 0. Counting is not retriggered; gate low pauses.
- Mode 5: as mode 4, but triggered by a gate rising edge; retriggerable.
- Mode 2/3 terminal counts reload from the count register. A rewrite takes effect at the next reload (or immediately in mode 0).
- Simultaneous ctrl_we and data_we: control wins, and the data byte is discarded.
- Simultaneous gate edge and terminal count: the retrigger wins.

Optional Feature:
- I8254_BCD_EN defined: BCD=1 selects 4-digit-per-16-bit BCD decrement; invalid nibbles wrap as BCD 9.
- I8254_BCD_EN undefined: the BCD bit is stored and read back, but counting is always binary.

Decomposition:
- Package i8254_pkg:
  - mode constants MODE0..MODE5;
  - RW constants RW_LATCH/RW_LSB/RW_MSB/RW_WORD;
  - state enum IDLE/ARMED/LOAD_PEND/COUNTING;
  - control-word field positions.
- Sub-module i8254_decrementer: combinational count-minus-1/minus-2 in binary or BCD, plus terminal-count flags.

Test Plan:
- Reset → out=0, null_count=1, count_value=0, data_out=0.
- Mode 0: ctrl 110000, write 0x05, 0x00, gate=1, ticks → null_count drops on the first tick; out rises on the 6th tick and stays high.
- Mode 2: ctrl 010100, write 0x04, gate=1 → out low one tick every 4 ticks. Drop gate → out=1 and count frozen.
- Mode 3, N=5 → out 3 ticks high, 2 ticks low, repeating.
- Mode 1: ctrl 110010, write 0x0003, pulse gate → out low 3 ticks. Re-pulse gate mid-count → low period extends to 3 ticks from the retrigger.
- Latch: count at 0x1234, ctrl 000000, two more ticks, two reads → 0x34 then 0x12. A second latch command before the reads completes is ignored.

Source files
------------

// File: rtl/i8254_pkg.sv
// Shared definitions for the 8254-style counter channel.
// Provides mode/RW encodings, the channel state enum, control-word field
// positions and the mode-alias helper.
package i8254_pkg;

  localparam logic [2:0] MODE0 = 3'd0;
  localparam logic [2:0] MODE1 = 3'd1;
  localparam logic [2:0] MODE2 = 3'd2;
  localparam logic [2:0] MODE3 = 3'd3;
  localparam logic [2:0] MODE4 = 3'd4;
  localparam logic [2:0] MODE5 = 3'd5;

  localparam logic [1:0] RW_LATCH = 2'b00;
  localparam logic [1:0] RW_LSB   = 2'b01;
  localparam logic [1:0] RW_MSB   = 2'b10;
  localparam logic [1:0] RW_WORD  = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    LOAD_PEND,
    COUNTING
  } state_e;

  // Control word layout: {RW[1:0], M[2:0], BCD}
  localparam int unsigned CW_BCD    = 0;
  localparam int unsigned CW_M_LSB  = 1;
  localparam int unsigned CW_M_MSB  = 3;
  localparam int unsigned CW_RW_LSB = 4;
  localparam int unsigned CW_RW_MSB = 5;

  // M=110/111 alias modes 2/3
  function automatic logic [2:0] norm_mode(input logic [2:0] m);
    return {m[2] & ~m[1], m[1:0]};
  endfunction

endpackage

// File: rtl/i8254_decrementer.sv
// Combinational count decrementer: value-1 and value-2 in binary or BCD,
// with zero flags on both results.
// Ports: value_i (count), bcd_i (BCD select), dec1_o/dec2_o (results),
//        dec1_zero_o/dec2_zero_o (result == 0).
// Build option: I8254_BCD_EN enables BCD arithmetic; otherwise bcd_i is
// ignored and arithmetic is always binary.
module i8254_decrementer #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] value_i,
  input  logic             bcd_i,
  output logic [WIDTH-1:0] dec1_o,
  output logic [WIDTH-1:0] dec2_o,
  output logic             dec1_zero_o,
  output logic             dec2_zero_o
);

`ifdef I8254_BCD_EN
  // Digit-serial BCD subtract; an invalid nibble is taken as 9.
  function automatic logic [WIDTH-1:0] bcd_sub(input logic [WIDTH-1:0] v,
                                               input logic [3:0]       amt);
    logic [WIDTH-1:0] r;
    logic [4:0]       d;
    logic [4:0]       sub;
    logic             borrow;
    r      = '0;
    borrow = 1'b0;
    for (int unsigned i = 0; i < WIDTH / 4; i++) begin
      d   = {1'b0, v[i*4 +: 4]};
      if (d > 5'd9) d = 5'd9;
      sub = (i == 0) ? {1'b0, amt} : {4'b0, borrow};
      if (d >= sub) begin
        r[i*4 +: 4] = 4'(d - sub);
        borrow      = 1'b0;
      end else begin
        r[i*4 +: 4] = 4'(d + 5'd10 - sub);
        borrow      = 1'b1;
      end
    end
    return r;
  endfunction

  assign dec1_o = bcd_i ? bcd_sub(value_i, 4'd1) : value_i - WIDTH'(1);
  assign dec2_o = bcd_i ? bcd_sub(value_i, 4'd2) : value_i - WIDTH'(2);
`else
  logic unused_bcd;
  assign unused_bcd = bcd_i;
  assign dec1_o     = value_i - WIDTH'(1);
  assign dec2_o     = value_i - WIDTH'(2);
`endif

  assign dec1_zero_o = (dec1_o == '0);
  assign dec2_zero_o = (dec2_o == '0);

endmodule

// File: rtl/i8254_counter_channel.sv
// One 8254-style counter channel: control-word decode, count register
// load, six counting modes, counter latch and byte-wise read-back.
// Ports: clk/reset (sync, active high), cnt_tick (count strobe), gate,
//        ctrl_we/ctrl_word (control), data_we/data_in (count bytes),
//        data_re/data_out (read-back), out, count_value, null_count.
// Build option: I8254_BCD_EN enables BCD counting in the decrementer.
module i8254_counter_channel
  import i8254_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cnt_tick,
  input  logic             gate,
  input  logic             ctrl_we,
  input  logic [5:0]       ctrl_word,
  input  logic             data_we,
  input  logic [7:0]       data_in,
  input  logic             data_re,
  output logic [7:0]       data_out,
  output logic             out,
  output logic [WIDTH-1:0] count_value,
  output logic             null_count
);

  localparam int unsigned BYTES = WIDTH / 8;
  localparam int unsigned PTR_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(BYTES - 1);

  logic [2:0]       mode_q, mode_d;
  logic [1:0]       rw_q, rw_d;
  logic             bcd_q, bcd_d;
  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] cr_q, cr_d;
  logic [WIDTH-1:0] stage_q, stage_d;
  logic [WIDTH-1:0] latch_q, latch_d;
  logic             latched_q, latched_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic             gate_q;
  logic             out_q, out_d;
  logic             null_q, null_d;
  logic [7:0]       dout_q, dout_d;

  logic [WIDTH-1:0] dec1, dec2, rd_src;
  logic             dec1_zero, dec2_zero;
  logic             gate_rise, retrig_mode, gated_mode, rd_last;
  logic [2:0]       cw_mode;
  logic [1:0]       cw_rw;

  i8254_decrementer #(.WIDTH(WIDTH)) u_dec (
    .value_i     (count_q),
    .bcd_i       (bcd_q),
    .dec1_o      (dec1),
    .dec2_o      (dec2),
    .dec1_zero_o (dec1_zero),
    .dec2_zero_o (dec2_zero)
  );

  assign gate_rise   = gate & ~gate_q;
  assign cw_mode     = norm_mode(ctrl_word[CW_M_MSB:CW_M_LSB]);
  assign cw_rw       = ctrl_word[CW_RW_MSB:CW_RW_LSB];
  assign retrig_mode = (mode_q == MODE1) || (mode_q == MODE2) ||
                       (mode_q == MODE3) || (mode_q == MODE5);
  assign gated_mode  = (mode_q == MODE2) || (mode_q == MODE3);

  // Next-state logic for the whole channel
  always_comb begin
    mode_d    = mode_q;
    rw_d      = rw_q;
    bcd_d     = bcd_q;
    state_d   = state_q;
    count_d   = count_q;
    cr_d      = cr_q;
    stage_d   = stage_q;
    latch_d   = latch_q;
    latched_d = latched_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    out_d     = out_q;
    null_d    = null_q;
    dout_d    = dout_q;
    rd_last   = 1'b0;
    rd_src    = latched_q ? latch_q : count_q;

    // Read-back: latched snapshot takes precedence over the live count
    if (data_re) begin
      case (rw_q)
        RW_LSB:  dout_d = rd_src[7:0];
        RW_MSB:  dout_d = rd_src[WIDTH-1 -: 8];
        default: dout_d = 8'(rd_src >> (8 * rd_ptr_q));
      endcase
      rd_last  = (rw_q != RW_WORD) || (rd_ptr_q == LAST_PTR);
      rd_ptr_d = rd_last ? '0 : rd_ptr_q + PTR_W'(1);
      if (rd_last) latched_d = 1'b0;
    end

    if (ctrl_we) begin
      if (cw_rw == RW_LATCH) begin
        if (!latched_q) begin
          latch_d   = count_q;
          latched_d = 1'b1;
        end
      end else begin
        mode_d    = cw_mode;
        rw_d      = cw_rw;
        bcd_d     = ctrl_word[CW_BCD];
        wr_ptr_d  = '0;
        rd_ptr_d  = '0;
        latched_d = 1'b0;
        null_d    = 1'b1;
        state_d   = IDLE;
        out_d     = (cw_mode != MODE0);
      end
    end else begin
      // Counting element
      case (state_q)
        ARMED: if (gate_rise) state_d = LOAD_PEND;
        LOAD_PEND: begin
          if (cnt_tick) begin
            count_d = cr_q;
            null_d  = 1'b0;
            state_d = COUNTING;
            out_d   = (mode_q != MODE0) && (mode_q != MODE1);
          end
        end
        COUNTING: begin
          if (gated_mode && !gate) out_d = 1'b1;
          // Retrigger has priority over a coincident terminal count
          if (gate_rise && retrig_mode) begin
            state_d = LOAD_PEND;
          end else if (cnt_tick) begin
            case (mode_q)
              MODE0: if (gate) begin
                count_d = dec1;
                if (dec1_zero) out_d = 1'b1;
              end
              MODE1: begin
                count_d = dec1;
                if (dec1_zero) out_d = 1'b1;
              end
              MODE2: if (gate) begin
                if (count_q == WIDTH'(1)) begin
                  count_d = cr_q;
                  null_d  = 1'b0;
                  out_d   = 1'b1;
                end else begin
                  count_d = dec1;
                  out_d   = (dec1 != WIDTH'(1));
                end
              end
              MODE3: if (gate) begin
                // Odd count steps by 1 once, then by 2; the low phase of an
                // odd reload starts from N-1 so high gets the extra tick.
                if (count_q[0] ? dec1_zero : dec2_zero) begin
                  out_d   = ~out_q;
                  count_d = out_q ? {cr_q[WIDTH-1:1], 1'b0} : cr_q;
                  null_d  = 1'b0;
                end else begin
                  count_d = count_q[0] ? dec1 : dec2;
                end
              end
              MODE4: if (gate) begin
                count_d = dec1;
                out_d   = ~dec1_zero;
              end
              default: begin
                count_d = dec1;
                out_d   = ~dec1_zero;
              end
            endcase
          end
        end
        default: ;
      endcase

      // Count register write sequence
      if (data_we) begin
        case (rw_q)
          RW_LSB: begin
            cr_d   = WIDTH'(data_in);
            null_d = 1'b1;
          end
          RW_MSB: begin
            cr_d   = WIDTH'(data_in) << (WIDTH - 8);
            null_d = 1'b1;
          end
          default: begin
            for (int unsigned b = 0; b < BYTES; b++) begin
              if (PTR_W'(b) == wr_ptr_q) stage_d[b*8 +: 8] = data_in;
            end
            if (wr_ptr_q == LAST_PTR) begin
              cr_d     = stage_d;
              null_d   = 1'b1;
              wr_ptr_d = '0;
            end else begin
              wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
          end
        endcase

        // Completed count: first load, or immediate restart in modes 0/4
        // (mode 4 never reloads on its own)
        if ((rw_q != RW_WORD) || (wr_ptr_q == LAST_PTR)) begin
          if (state_q == IDLE) begin
            state_d = ((mode_q == MODE1) || (mode_q == MODE5)) ? ARMED : LOAD_PEND;
          end else if ((mode_q == MODE0) || (mode_q == MODE4)) begin
            state_d = LOAD_PEND;
            if (mode_q == MODE0) out_d = 1'b0;
          end
        end
      end
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q    <= MODE0;
      rw_q      <= RW_WORD;
      bcd_q     <= 1'b0;
      state_q   <= IDLE;
      count_q   <= '0;
      cr_q      <= '0;
      stage_q   <= '0;
      latch_q   <= '0;
      latched_q <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      gate_q    <= 1'b0;
      out_q     <= 1'b0;
      null_q    <= 1'b1;
      dout_q    <= 8'h00;
    end else begin
      mode_q    <= mode_d;
      rw_q      <= rw_d;
      bcd_q     <= bcd_d;
      state_q   <= state_d;
      count_q   <= count_d;
      cr_q      <= cr_d;
      stage_q   <= stage_d;
      latch_q   <= latch_d;
      latched_q <= latched_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      gate_q    <= gate;
      out_q     <= out_d;
      null_q    <= null_d;
      dout_q    <= dout_d;
    end
  end

  assign data_out    = dout_q;
  assign out         = out_q;
  assign count_value = count_q;
  assign null_count  = null_q;

endmodule
